// File: rtl/ptcalc_prod_accum.sv
// ptcalc_prod_accum: sums a group of signed products from the 15x15 ptcalc
// multiplier stage and presents the result on a valid/ready output. A group is
// closed by prod_last_i or by reaching MAX_TERMS terms. The total is scaled by
// an arithmetic right shift, saturated to OUT_W bits and held until taken.
// Optional build macro: PTCALC_PROD_ACCUM_ROUND_EN (round half up before the
// shift instead of flooring).
module ptcalc_prod_accum #(
    parameter int PROD_W    = 30,
    parameter int ACC_W     = 36,
    parameter int OUT_W     = 18,
    parameter int SHIFT     = 12,
    parameter int MAX_TERMS = 8
) (
    input  logic                               ap_clk,
    input  logic                               ap_rst_n,
    input  logic [PROD_W-1:0]                  prod_i,
    input  logic                               prod_valid_i,
    input  logic                               prod_last_i,
    output logic                               prod_ready_o,
    output logic [OUT_W-1:0]                   sum_o,
    output logic                               sum_valid_o,
    input  logic                               sum_ready_i,
    output logic                               sum_sat_o,
    output logic                               err_o,
    output logic [$clog2(MAX_TERMS+1)-1:0]     nterms_o
);

    localparam int CNT_W = $clog2(MAX_TERMS + 1);
    // One guard bit so rounding and the clamp compare never wrap.
    localparam int EXT_W = ACC_W + 1;

    localparam logic signed [EXT_W-1:0] SAT_MAX = (EXT_W'(1) << (OUT_W - 1)) - EXT_W'(1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

`ifdef PTCALC_PROD_ACCUM_ROUND_EN
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [EXT_W-1:0] RND_ADD = (SHIFT > 0) ? (EXT_W'(1) << RND_POS) : '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_t;

    state_t                    state_q;
    logic [ACC_W-1:0]          acc_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [OUT_W-1:0]          sum_q;
    logic                      valid_q;
    logic                      sat_q;
    logic                      err_q;
    logic [CNT_W-1:0]          nterms_q;

    logic                      accept;
    logic                      close;
    logic [ACC_W-1:0]          prod_ext;
    logic [ACC_W-1:0]          acc_d;
    logic [CNT_W-1:0]          cnt_d;
    logic signed [EXT_W-1:0]   acc_ext;
    logic signed [EXT_W-1:0]   acc_rnd;
    logic signed [EXT_W-1:0]   shifted;
    logic [OUT_W-1:0]          sum_d;
    logic                      sat_d;

    assign prod_ready_o = (state_q != S_HOLD);
    assign accept       = prod_valid_i & prod_ready_o;

    // Next accumulator/count for an accepted term and the group-close decision.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        prod_ext = {{(ACC_W - PROD_W){prod_i[PROD_W-1]}}, prod_i};
        acc_d    = prod_ext;
        cnt_d    = CNT_W'(1);
        if (state_q == S_ACCUM) begin
            acc_d = acc_q + prod_ext;
            cnt_d = cnt_q + CNT_W'(1);
        end
        close = accept & (prod_last_i | (cnt_d == CNT_W'(MAX_TERMS)));
    end

    // Scale and saturate the final accumulator value feeding the output register.
    always_comb begin
        acc_ext = {acc_d[ACC_W-1], acc_d};
`ifdef PTCALC_PROD_ACCUM_ROUND_EN
        acc_rnd = acc_ext + RND_ADD;
`else
        acc_rnd = acc_ext;
`endif
        shifted = acc_rnd >>> SHIFT;
        sum_d   = shifted[OUT_W-1:0];
        sat_d   = 1'b0;
        if (shifted > SAT_MAX) begin
            sum_d = SAT_MAX[OUT_W-1:0];
            sat_d = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sum_d = SAT_MIN[OUT_W-1:0];
            sat_d = 1'b1;
        end
    end

    // Group FSM with accumulator and registered result fields.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            sum_q    <= '0;
            valid_q  <= 1'b0;
            sat_q    <= 1'b0;
            err_q    <= 1'b0;
            nterms_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            case (state_q)
                S_IDLE, S_ACCUM: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        if (close) begin
                            state_q  <= S_HOLD;
                            sum_q    <= sum_d;
                            sat_q    <= sat_d;
                            err_q    <= ~prod_last_i;
                            nterms_q <= cnt_d;
                            valid_q  <= 1'b1;
                        end else begin
                            state_q <= S_ACCUM;
                        end
                    end
                end
                S_HOLD: begin
                    if (sum_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sum_o       = sum_q;
    assign sum_valid_o = valid_q;
    assign sum_sat_o   = sat_q;
    assign err_o       = err_q;
    assign nterms_o    = nterms_q;

endmodule
